// File: rtl/sfm_row_sequencer.sv
// Splits one softmax job into per-row ACC/DRAIN/REDUCE/DIV passes with strided addresses.
// Optional busy-cycle counter enabled by defining SFM_ROW_SEQ_PERF_CNT_EN.
module sfm_row_sequencer #(
   parameter int ADDR_WIDTH = 32,
   parameter int LEN_WIDTH  = 32,
   parameter int ROW_W      = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  clear_i,
   input  logic                  start_i,
   input  logic [ADDR_WIDTH-1:0] in_base_i,
   input  logic [ADDR_WIDTH-1:0] out_base_i,
   input  logic [ADDR_WIDTH-1:0] row_stride_i,
   input  logic [LEN_WIDTH-1:0]  row_len_i,
   input  logic [ROW_W-1:0]      n_rows_i,
   output logic                  in_req_start_o,
   output logic [ADDR_WIDTH-1:0] in_base_addr_o,
   output logic [LEN_WIDTH-1:0]  in_tot_len_o,
   input  logic                  in_done_i,
   output logic                  out_req_start_o,
   output logic [ADDR_WIDTH-1:0] out_base_addr_o,
   output logic [LEN_WIDTH-1:0]  out_tot_len_o,
   input  logic                  out_done_i,
   input  logic                  dp_busy_i,
   input  logic                  dp_reducing_i,
   output logic                  dp_acc_finished_o,
   output logic                  dp_dividing_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [ROW_W-1:0]      row_idx_o,
   output logic [31:0]           cycles_o
);

   typedef enum logic [2:0] {S_IDLE, S_ACC, S_DRAIN, S_REDUCE, S_DIV, S_NEXT} state_t;

   state_t                state_reg;
   logic [ADDR_WIDTH-1:0] in_addr_reg;
   logic [ADDR_WIDTH-1:0] out_addr_reg;
   logic [ADDR_WIDTH-1:0] stride_reg;
   logic [LEN_WIDTH-1:0]  len_reg;
   logic [ROW_W-1:0]      n_rows_reg;
   logic [ROW_W-1:0]      row_idx_reg;
   logic                  in_start_reg;
   logic                  out_start_reg;
   logic                  acc_fin_reg;
   logic                  div_reg;
   logic                  busy_reg;
   logic                  done_reg;
   logic                  more_rows;

   // Widened by one bit so row_idx + 1 cannot overflow at the maximum row count.
   assign more_rows = ({1'b0, row_idx_reg} + (ROW_W+1)'(1)) < {1'b0, n_rows_reg};

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         state_reg     <= S_IDLE;
         in_addr_reg   <= '0;
         out_addr_reg  <= '0;
         stride_reg    <= '0;
         len_reg       <= '0;
         n_rows_reg    <= '0;
         row_idx_reg   <= '0;
         in_start_reg  <= 1'b0;
         out_start_reg <= 1'b0;
         acc_fin_reg   <= 1'b0;
         div_reg       <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
      end else begin
         in_start_reg  <= 1'b0;
         out_start_reg <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (start_i) begin
                  in_addr_reg  <= in_base_i;
                  out_addr_reg <= out_base_i;
                  stride_reg   <= row_stride_i;
                  len_reg      <= row_len_i;
                  // A zero-length row makes the whole job empty.
                  n_rows_reg   <= (row_len_i == '0) ? '0 : n_rows_i;
                  row_idx_reg  <= '0;
                  busy_reg     <= 1'b1;
                  if (n_rows_i == '0 || row_len_i == '0) begin
                     state_reg <= S_NEXT;
                  end else begin
                     state_reg    <= S_ACC;
                     in_start_reg <= 1'b1;
                  end
               end
            end
            S_ACC: begin
               if (in_done_i) state_reg <= S_DRAIN;
            end
            S_DRAIN: begin
               if (!dp_busy_i) begin
                  acc_fin_reg <= 1'b1;
                  state_reg   <= S_REDUCE;
               end
            end
            S_REDUCE: begin
               if (dp_reducing_i) begin
                  acc_fin_reg   <= 1'b0;
                  in_start_reg  <= 1'b1;
                  out_start_reg <= 1'b1;
                  div_reg       <= 1'b1;
                  state_reg     <= S_DIV;
               end
            end
            S_DIV: begin
               if (out_done_i) begin
                  div_reg   <= 1'b0;
                  state_reg <= S_NEXT;
               end
            end
            S_NEXT: begin
               // After the last row NEXT spans two cycles: decide, then the done cycle.
               if (done_reg) begin
                  done_reg  <= 1'b0;
                  busy_reg  <= 1'b0;
                  state_reg <= S_IDLE;
               end else if (more_rows) begin
                  row_idx_reg  <= row_idx_reg + ROW_W'(1);
                  in_addr_reg  <= in_addr_reg + stride_reg;
                  out_addr_reg <= out_addr_reg + stride_reg;
                  in_start_reg <= 1'b1;
                  state_reg    <= S_ACC;
               end else begin
                  done_reg <= 1'b1;
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   assign in_req_start_o    = in_start_reg;
   assign out_req_start_o   = out_start_reg;
   assign in_base_addr_o    = in_addr_reg;
   assign out_base_addr_o   = out_addr_reg;
   assign in_tot_len_o      = len_reg;
   assign out_tot_len_o     = len_reg;
   assign dp_acc_finished_o = acc_fin_reg;
   assign dp_dividing_o     = div_reg;
   assign busy_o            = busy_reg;
   assign done_o            = done_reg;
   assign row_idx_o         = row_idx_reg;

`ifdef SFM_ROW_SEQ_PERF_CNT_EN
   logic [31:0] cycles_reg;

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         cycles_reg <= '0;
      end else if (state_reg == S_IDLE && start_i) begin
         cycles_reg <= '0;
      end else if (busy_reg && cycles_reg != 32'hFFFF_FFFF) begin
         cycles_reg <= cycles_reg + 32'd1;
      end
   end

   assign cycles_o = cycles_reg;
`else
   assign cycles_o = 32'd0;
`endif

endmodule

// File: doc/sfm_row_sequencer.md
# sfm_row_sequencer

Multi-row job sequencer for the softmax accelerator. It sits between the register file and the two HCI streamers and the softmax datapath, and splits one programmed job of `n_rows` independent softmax rows into per-row passes. Each row gets an accumulation pass, a datapath drain, a reduction handshake and a division pass. Source and destination base addresses advance by a row stride after each row. It raises one completion pulse when the last row's output stream finishes.

## Interface
- `ADDR_WIDTH`, 32: byte-address width of base addresses and stride.
- `LEN_WIDTH`, 32: width of the per-row stream length, in beats.
- `ROW_W`, 16: width of the row count and row index.
- `clk_i`  in  1  clock; the only clock.
- `rst_i`  in  1  reset; synchronous, active-high.
- `clear_i`  in  1  synchronous soft clear; same effect as reset.
- `start_i`  in  1  job start pulse; honoured only in IDLE.
- `in_base_i` / `out_base_i`  in  ADDR_WIDTH  row-0 source / destination byte address.
- `row_stride_i`  in  ADDR_WIDTH  byte offset between consecutive rows.
- `row_len_i`  in  LEN_WIDTH  beats per row (streamer `tot_len`).
- `n_rows_i`  in  ROW_W  number of rows in the job.
- `in_req_start_o`  out  1  input streamer start pulse.
- `in_base_addr_o`  out  ADDR_WIDTH  current input row address.
- `in_tot_len_o`  out  LEN_WIDTH  latched row length.
- `in_done_i`  in  1  input streamer done pulse.
- `out_req_start_o`  out  1  output streamer start pulse.
- `out_base_addr_o`  out  ADDR_WIDTH  current output row address.
- `out_tot_len_o`  out  LEN_WIDTH  latched row length.
- `out_done_i`  in  1  output streamer done pulse.
- `dp_busy_i`  in  1  datapath still holds in-flight data.
- `dp_reducing_i`  in  1  accumulator has started its final reduction.
- `dp_acc_finished_o`  out  1  tells the accumulator the input stream is complete.
- `dp_dividing_o`  out  1  puts the datapath in division mode.
- `busy_o`  out  1  high from start acceptance until the done pulse.
- `done_o`  out  1  one-cycle job-complete pulse.
- `row_idx_o`  out  ROW_W  index of the row in progress.
- `cycles_o`  out  32  busy-cycle count (see Configuration).

## Operation
- States: IDLE, ACC, DRAIN, REDUCE, DIV, NEXT.
- **IDLE, start_i high:**
  - Latch `in_base_i`, `out_base_i`, `row_stride_i`, `row_len_i` and `n_rows_i`; clear `row_idx`.
  - If `n_rows_i == 0` or `row_len_i == 0`, go to NEXT with zero rows. Otherwise go to ACC.
- **ACC:**
  - `in_req_start_o` is high in the first cycle of ACC only.
  - On `in_done_i`, go to DRAIN.
- **DRAIN:** when `dp_busy_i` is low, assert `dp_acc_finished_o` and go to REDUCE.
- **REDUCE:**
  - `dp_acc_finished_o` stays high.
  - On `dp_reducing_i`, drop `dp_acc_finished_o`, assert `in_req_start_o` and `out_req_start_o` in that same cycle (input is re-streamed for division), and go to DIV.
- **DIV:**
  - `dp_dividing_o` is high.
  - On `out_done_i`, drop `dp_dividing_o` in that cycle and go to NEXT.
- **NEXT:**
  - If `row_idx + 1 < n_rows`: increment `row_idx`, add the stride to both addresses, go to ACC.
  - Otherwise: pulse `done_o`, go to IDLE.
  - The zero-row case always pulses `done_o`.
- **Address arithmetic:**
  - Addresses are updated incrementally by adding `row_stride`.
  - Results are modulo 2^ADDR_WIDTH; wrap-around is silent.
  - Row count comparison is unsigned.
- Unexpected events are ignored: `in_done_i` outside ACC, `out_done_i` outside DIV, `dp_reducing_i` outside REDUCE.
- `start_i` while busy is ignored; the latched configuration is unchanged.
- Simultaneous `start_i` and `clear_i`: clear wins.

## Timing
- On reset or clear, all outputs are 0: state IDLE, addresses 0, lengths 0, `row_idx_o` 0. `cycles_o` is also 0.
- Reset and clear take effect at the next rising edge. A job in progress is abandoned and no `done_o` is produced.
- With `start_i` sampled high at edge t:
  - `busy_o` and the first `in_req_start_o` appear in cycle t+1.
  - Address and length outputs are valid from t+1 and remain stable within a row.
- DRAIN→REDUCE and REDUCE→DIV each take at least one cycle.
- Row turnaround is 2 cycles: NEXT, then the ACC start cycle.
- The `done_o` cycle is the NEXT cycle. `busy_o` falls in the following cycle (IDLE).
- A new `start_i` is accepted in the first IDLE cycle after `done_o`.

## Configuration
- Macro `SFM_ROW_SEQ_PERF_CNT_EN`.
- Defined:
  - `cycles_o` counts every cycle `busy_o` is high, saturating at 2^32-1.
  - It clears on acceptance of `start_i` and holds its value after done.
- Undefined: `cycles_o` is tied to 0 and no counter is instantiated.

## Test plan
- `n_rows=3`, `row_len=4`, `in_base=0x1000`, `out_base=0x2000`, `stride=0x40` -> `in_base_addr_o` takes 0x1000, 0x1040, 0x1080, `out_base_addr_o` takes 0x2000, 0x2040, 0x2080; exactly 6 `in_req_start_o` and 3 `out_req_start_o` pulses; one `done_o`.
- `n_rows=0` -> `done_o` one cycle after NEXT, no streamer starts, `busy_o` high for exactly 2 cycles.
- Hold `dp_busy_i` high for 10 cycles after `in_done_i` -> `dp_acc_finished_o` rises only after `dp_busy_i` falls, then stays high until `dp_reducing_i`.
- `in_base=0xFFFF_FFC0`, `stride=0x40`, `n_rows=2` -> second-row address 0x0000_0000.
- Assert `clear_i` during DIV of row 1 -> next cycle all outputs 0, no `done_o`; a new start runs normally.
- With `SFM_ROW_SEQ_PERF_CNT_EN` defined, single row, fixed stub latencies -> `cycles_o` equals the number of `busy_o`-high cycles; with it undefined, `cycles_o` stays 0.
